// File: rtl/voice_allocator_pkg.sv
// Shared sizing and key-index constants for the keyboard polyphony scheduler.
package voice_allocator_pkg;

    localparam int NUM_KEYS   = 48;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 6;
    localparam int VIDX_W     = $clog2(NUM_VOICES);
    localparam int COUNT_W    = 3;

    localparam logic [KEY_W-1:0] OCT0_BASE = KEY_W'(0);
    localparam logic [KEY_W-1:0] OCT1_BASE = KEY_W'(12);
    localparam logic [KEY_W-1:0] OCT2_BASE = KEY_W'(24);
    localparam logic [KEY_W-1:0] OCT3_BASE = KEY_W'(36);

    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);

    function automatic logic [COUNT_W-1:0] popcount_voices(input logic [NUM_VOICES-1:0] bits);
        logic [COUNT_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            total = total + {{(COUNT_W-1){1'b0}}, bits[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/voice_allocator_free_finder.sv
// Combinational search for the lowest-index idle voice.
import voice_allocator_pkg::*;

module voice_free_finder (
    input  logic [NUM_VOICES-1:0] voice_active,
    output logic                  free_found,
    output logic [VIDX_W-1:0]     free_idx
);

    // Walk downwards so the lowest free voice is the last one written.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Scans one key per enabled cycle and assigns/releases tone-generator voices.
import voice_allocator_pkg::*;

module voice_allocator (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        all_off,
    input  logic [NUM_KEYS-1:0]         pressed_key,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       voice_on,
    output logic [NUM_VOICES-1:0]       voice_off,
    output logic                        overflow,
    output logic [COUNT_W-1:0]          voice_count
);

    logic [KEY_W-1:0]      scan_idx;
    logic [KEY_W-1:0]      scan_idx_nxt;
    logic [KEY_W-1:0]      key_q   [NUM_VOICES];
    logic [KEY_W-1:0]      key_nxt [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_nxt;
    logic [NUM_VOICES-1:0] on_nxt;
    logic [NUM_VOICES-1:0] off_nxt;
    logic                  overflow_nxt;
    logic                  owned;
    logic [VIDX_W-1:0]     owner_idx;
    logic                  free_found;
    logic [VIDX_W-1:0]     free_idx;
    logic                  key_down;

    voice_free_finder u_free_finder (
        .voice_active (voice_active),
        .free_found   (free_found),
        .free_idx     (free_idx)
    );

    assign key_down = pressed_key[scan_idx];

    always_comb begin
        owned     = 1'b0;
        owner_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v] && (key_q[v] == scan_idx)) begin
                owned     = 1'b1;
                owner_idx = VIDX_W'(v);
            end
        end
    end

    always_comb begin
        scan_idx_nxt = scan_idx;
        if (enable) begin
            scan_idx_nxt = (scan_idx == LAST_KEY) ? '0 : scan_idx + KEY_W'(1);
        end
    end

    // Panic release wins over the scan; the scan counter still advances.
    always_comb begin
        active_nxt   = voice_active;
        on_nxt       = '0;
        off_nxt      = '0;
        overflow_nxt = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            key_nxt[v] = key_q[v];
        end
        if (all_off) begin
            off_nxt    = voice_active;
            active_nxt = '0;
        end else if (enable) begin
            if (key_down && !owned) begin
                if (free_found) begin
                    active_nxt[free_idx] = 1'b1;
                    key_nxt[free_idx]    = scan_idx;
                    on_nxt[free_idx]     = 1'b1;
                end else begin
                    overflow_nxt = 1'b1;
                end
            end else if (!key_down && owned) begin
                active_nxt[owner_idx] = 1'b0;
                off_nxt[owner_idx]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx     <= '0;
            voice_active <= '0;
            voice_on     <= '0;
            voice_off    <= '0;
            overflow     <= 1'b0;
            voice_count  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_q[v] <= '0;
            end
        end else begin
            scan_idx     <= scan_idx_nxt;
            voice_active <= active_nxt;
            voice_on     <= on_nxt;
            voice_off    <= off_nxt;
            overflow     <= overflow_nxt;
            voice_count  <= popcount_voices(active_nxt);
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_q[v] <= key_nxt[v];
            end
        end
    end

    always_comb begin
        voice_key = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_key[v*KEY_W +: KEY_W] = key_q[v];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: per-cycle reference-model scoreboard plus phase table and corner sequences.
module tb_voice_allocator;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        all_off;
    logic [47:0] pressed_key;
    logic [3:0]  voice_active;
    logic [23:0] voice_key;
    logic [3:0]  voice_on;
    logic [3:0]  voice_off;
    logic        overflow;
    logic [2:0]  voice_count;

    voice_allocator dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .all_off      (all_off),
        .pressed_key  (pressed_key),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .voice_on     (voice_on),
        .voice_off    (voice_off),
        .overflow     (overflow),
        .voice_count  (voice_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  active;
        logic [23:0] key;
        logic [3:0]  on;
        logic [3:0]  off;
        logic        ovf;
        logic [2:0]  count;
    } out_t;

    typedef struct {
        int          n;
        logic        en;
        logic        ao;
        logic [47:0] pk;
        logic [3:0]  act;
        logic [23:0] key;
        logic [2:0]  cnt;
        int          ovf;
    } row_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ovf_seen = 0;
    int   cyc      = 0;

    int         m_idx;
    logic [3:0] m_active;
    logic [5:0] m_key [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic model_eval(input logic r, input logic en, input logic ao,
                              input logic [47:0] pk, output out_t e);
        int own;
        int fr;
        e = '0;
        if (r) begin
            m_idx    = 0;
            m_active = '0;
            for (int v = 0; v < 4; v++) m_key[v] = '0;
        end else begin
            if (ao) begin
                e.off    = m_active;
                m_active = '0;
            end else if (en) begin
                own = -1;
                fr  = -1;
                for (int v = 0; v < 4; v++)
                    if (m_active[v] && m_key[v] == 6'(m_idx)) own = v;
                for (int v = 3; v >= 0; v--)
                    if (!m_active[v]) fr = v;
                if (pk[m_idx] && own < 0) begin
                    if (fr >= 0) begin
                        m_active[fr] = 1'b1;
                        m_key[fr]    = 6'(m_idx);
                        e.on[fr]     = 1'b1;
                    end else begin
                        e.ovf = 1'b1;
                    end
                end else if (!pk[m_idx] && own >= 0) begin
                    m_active[own] = 1'b0;
                    e.off[own]    = 1'b1;
                end
            end
            if (en) m_idx = (m_idx + 1) % 48;
        end
        e.active = m_active;
        for (int v = 0; v < 4; v++) e.key[v*6 +: 6] = m_key[v];
        e.count = 3'($countones(m_active));
    endtask

    task automatic step(input logic r, input logic en, input logic ao, input logic [47:0] pk);
        out_t e;
        out_t got;
        reset       = r;
        enable      = en;
        all_off     = ao;
        pressed_key = pk;
        model_eval(r, en, ao, pk, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = {voice_active, voice_key, voice_on, voice_off, overflow, voice_count};
        e = exp_q.pop_front();
        if (overflow === 1'b1) ovf_seen++;
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL cycle %0d: got act=%b key=%h on=%b off=%b ovf=%b cnt=%0d expected act=%b key=%h on=%b off=%b ovf=%b cnt=%0d",
                     cyc, got.active, got.key, got.on, got.off, got.ovf, got.count,
                     e.active, e.key, e.on, e.off, e.ovf, e.count);
        end
    endtask

    row_t rows [9];

    initial begin
        int waited;
        bit seen;

        rows[0] = '{96, 1'b1, 1'b0, 48'h0,     4'b0000, 24'h0,                           3'd0, 0};
        rows[1] = '{48, 1'b1, 1'b0, 48'h1000,  4'b0001, {6'd0, 6'd0, 6'd0, 6'd12},       3'd1, 0};
        rows[2] = '{48, 1'b1, 1'b0, 48'h0,     4'b0000, {6'd0, 6'd0, 6'd0, 6'd12},       3'd0, 0};
        rows[3] = '{96, 1'b1, 1'b0, 48'hAA8,   4'b1111, {6'd9, 6'd7, 6'd5, 6'd3},        3'd4, 2};
        rows[4] = '{48, 1'b1, 1'b0, 48'hA88,   4'b1111, {6'd9, 6'd7, 6'd11, 6'd3},       3'd4, 0};
        rows[5] = '{1,  1'b1, 1'b1, 48'hA88,   4'b0000, {6'd9, 6'd7, 6'd11, 6'd3},       3'd0, 0};
        rows[6] = '{48, 1'b1, 1'b0, 48'hA88,   4'b1111, {6'd11, 6'd9, 6'd7, 6'd3},       3'd4, 0};
        rows[7] = '{20, 1'b0, 1'b0, 48'h8,     4'b1111, {6'd11, 6'd9, 6'd7, 6'd3},       3'd4, 0};
        rows[8] = '{48, 1'b1, 1'b0, 48'h8,     4'b0001, {6'd11, 6'd9, 6'd7, 6'd3},       3'd1, 0};

        reset = 1'b1; enable = 1'b0; all_off = 1'b0; pressed_key = '0;
        step(1'b1, 1'b0, 1'b0, 48'h0);
        step(1'b1, 1'b1, 1'b0, 48'h0);
        check("reset_active", 32'(voice_active), 32'h0);
        check("reset_count",  32'(voice_count),  32'h0);

        for (int r = 0; r < 9; r++) begin
            ovf_seen = 0;
            for (int c = 0; c < rows[r].n; c++) step(1'b0, rows[r].en, rows[r].ao, rows[r].pk);
            check($sformatf("row%0d_active", r), 32'(voice_active), 32'(rows[r].act));
            check($sformatf("row%0d_key", r),    32'(voice_key),    32'(rows[r].key));
            check($sformatf("row%0d_count", r),  32'(voice_count),  32'(rows[r].cnt));
            check($sformatf("row%0d_ovf", r),    32'(ovf_seen),     32'(rows[r].ovf));
        end

        // Scan now sits at key 1; 29 more cycles reach key 30 with keys 3,5,7 held.
        for (int c = 0; c < 29; c++) step(1'b0, 1'b1, 1'b0, 48'hA8);
        check("pre_reset_count", 32'(voice_count), 32'd3);
        step(1'b1, 1'b1, 1'b0, 48'hA8);
        check("midscan_reset_active", 32'(voice_active), 32'h0);
        check("midscan_reset_key",    32'(voice_key),    32'h0);
        check("midscan_reset_count",  32'(voice_count),  32'h0);

        // After reset the scan restarts at 0, so key 1 is granted on the second cycle.
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 6) begin
            step(1'b0, 1'b1, 1'b0, 48'h2);
            waited++;
            if (voice_on === 4'b0001) seen = 1'b1;
        end
        check("restart_latency", 32'(waited), 32'd2);
        check("restart_key0",    32'(voice_key[5:0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler for the keyboard front end.
- Consumes the registered 48-bit pressed-key vector from the keyboard decoder.
- Shares a small pool of tone-generator voices among the 48 keys:
  - assigns a free voice to each newly held key;
  - frees the voice when the key is released.
- Sits between the key decoder and the tone-generator/mixer bank; each voice slot drives one tone generator.

Parameters:
- NUM_KEYS, 48: number of key request lines (4 octaves x 12).
- NUM_VOICES, 4: number of tone-generator voices in the pool.
- KEY_W, 6: width of a key index; must satisfy 2^KEY_W >= NUM_KEYS.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- enable  in  1  scan advance enable; low freezes all state.
- all_off  in  1  panic: release every voice this cycle.
- pressed_key  in  NUM_KEYS  level-held key vector; bit i = key i down.
- voice_active  out  NUM_VOICES  bit v = voice v is sounding.
- voice_key  out  NUM_VOICES*KEY_W  packed key index per voice; voice v at [v*KEY_W +: KEY_W].
- voice_on  out  NUM_VOICES  one-cycle pulse: voice v just allocated.
- voice_off  out  NUM_VOICES  one-cycle pulse: voice v just released.
- overflow  out  1  one-cycle pulse: new key found, no free voice.
- voice_count  out  3  number of active voices, 0..NUM_VOICES.

Behaviour:
- Reset values:
  - scan_idx = 0;
  - voice_active, voice_key, voice_on, voice_off, overflow, voice_count all 0.
  - Reset mid-scan aborts immediately; there is no pending work.
- Scan counter scan_idx, KEY_W bits:
  - increments by 1 on each clk with enable=1;
  - wraps NUM_KEYS-1 -> 0;
  - holds when enable=0.
  - Full sweep = NUM_KEYS enabled cycles.
- owned(i), combinational: any v with voice_active[v]=1 and voice_key[v]=i. At most one voice may own a key (invariant).
- Per enabled cycle, evaluate key k = scan_idx. Exactly one action:
  - NEW: pressed_key[k]=1 and !owned(k).
    - Lowest-index free voice f gets voice_key[f]<=k, voice_active[f]<=1, voice_on[f] pulse.
    - If no voice is free: overflow pulse; no voice changes. There is no stealing. The key is re-tried on the next sweep.
  - RELEASE: pressed_key[k]=0 and owned(k).
    - The owning voice o gets voice_active[o]<=0 and a voice_off[o] pulse.
    - voice_key[o] retains its last value.
  - Otherwise: no change.
- Outputs are registered. Allocation/release is visible the cycle after the scan hits k.
  - Worst-case latency from key edge to output: NUM_KEYS+1 enabled cycles.
- all_off=1 (enable ignored):
  - every active voice clears;
  - voice_off pulses for all previously active voices;
  - no allocation that cycle;
  - scan_idx still advances if enable=1.
  - all_off has priority over NEW/RELEASE.
- A key pressed and released between two visits is never seen. This is acceptable.
- voice_count is updated together with voice_active. Its registered value equals popcount(voice_active).
- Pulses are 0 in every cycle with no event, including enable=0 cycles.

Decomposition:
- Shared package holds:
  - NUM_KEYS, NUM_VOICES, KEY_W;
  - key-index constants for octave base positions (0, 12, 24, 36).
- Sub-module voice_free_finder (combinational):
  - input voice_active;
  - outputs free_found and free_idx (lowest zero bit).
- Owner match is an inline comparator loop.

Test Plan:
- Reset then pressed_key=0 for 96 cycles -> voice_active=0, no pulses, scan_idx wraps 47->0 twice.
- Set bit 12 at scan_idx=0 -> at idx 12: voice_on[0] pulse next cycle, voice_key[0]=12, voice_count=1. Clear bit 12 -> on next visit: voice_off[0] pulse, voice_active=0.
- Hold keys 3, 5, 7, 9, 11 -> voices 0..3 take keys 3, 5, 7, 9. At idx 11: overflow pulse, every sweep. Release key 5 -> voice 1 frees; next visit to 11: voice_key[1]=11.
- 4 voices active, assert all_off for one cycle -> voice_off=4'b1111 pulse, voice_count=0. With keys still held, they are reallocated on the next sweep.
- enable=0 for 20 cycles with a key change pending -> scan_idx, voices and pulses frozen; scanning resumes on enable=1.
- Assert reset while voice_count=3 at scan_idx=30 -> next cycle all outputs 0, scan_idx=0.
